// File: rtl/iob_eth_mdio_pkg.sv
// Shared types and frame constants for the MDIO management controller.
// Preamble generation is selected with IOB_ETH_MDIO_PREAMBLE_EN.
package iob_eth_mdio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StHdr,
        StTa,
        StData,
        StDone
    } mdio_state_e;

    localparam int unsigned PRE_LEN  = 32;
    localparam int unsigned HDR_LEN  = 14;
    localparam int unsigned DATA_LEN = 16;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] TA_WR = 2'b10;

    // Read frames carry ones past the header; those bits are never driven.
    function automatic logic [31:0] build_frame(input logic        write,
                                                input logic [4:0]  phyad,
                                                input logic [4:0]  regad,
                                                input logic [15:0] wdata);
        if (write) begin
            return {ST, OP_WR, phyad, regad, TA_WR, wdata};
        end
        return {ST, OP_RD, phyad, regad, 2'b11, 16'hFFFF};
    endfunction

endpackage

// File: rtl/iob_eth_mdc_gen.sv
// MDC divider: low for MDC_DIV cycles, then high for MDC_DIV cycles, while en is set.
// rise_en/fall_en mark the clk edges where mdc goes 0->1 and 1->0.
module iob_eth_mdc_gen #(
    parameter int unsigned MDC_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise_en,
    output logic fall_en
);

    localparam logic [8:0] HalfM1 = 9'(MDC_DIV - 1);
    localparam logic [8:0] Half   = 9'(MDC_DIV);
    localparam logic [8:0] Last   = 9'(2 * MDC_DIV - 1);

    logic [8:0] cnt_q, cnt_d;
    logic       mdc_q, mdc_d;

    always_comb begin
        rise_en = en && (cnt_q == HalfM1);
        fall_en = en && (cnt_q == Last);
        cnt_d   = '0;
        if (en && !fall_en) begin
            cnt_d = cnt_q + 9'd1;
        end
        mdc_d = en && (cnt_d >= Half);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc = mdc_q;

endmodule

// File: rtl/iob_eth_mdio_ctrl.sv
// IEEE 802.3 clause-22 MDIO master: one read or write frame per accepted command.
// Define IOB_ETH_MDIO_PREAMBLE_EN to prefix every frame with a 32-bit preamble.
module iob_eth_mdio_ctrl
    import iob_eth_mdio_pkg::*;
#(
    parameter int unsigned MDC_DIV = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

`ifdef IOB_ETH_MDIO_PREAMBLE_EN
    localparam mdio_state_e FirstSt = StPre;
`else
    localparam mdio_state_e FirstSt = StHdr;
`endif

    mdio_state_e state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] frame_q, frame_d;
    logic        write_q, write_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mdc_en, rise_en, fall_en;

    assign mdc_en = (state_q == StPre) || (state_q == StHdr) ||
                    (state_q == StTa)  || (state_q == StData);

    iob_eth_mdc_gen #(
        .MDC_DIV (MDC_DIV)
    ) u_mdc_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (mdc_en),
        .mdc     (mdc),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        write_d   = write_q;
        rd_sh_d   = rd_sh_q;
        rdata_d   = rdata_q;
        mdio_o    = 1'b1;
        mdio_oe   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    frame_d   = build_frame(cmd_write, cmd_phyad, cmd_regad, cmd_wdata);
                    bit_cnt_d = '0;
                    state_d   = FirstSt;
                end
            end
            StPre: begin
                mdio_oe = 1'b1;
                if (fall_en) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(PRE_LEN - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StHdr;
                    end
                end
            end
            StHdr: begin
                mdio_oe = 1'b1;
                mdio_o  = frame_q[31];
                if (fall_en) begin
                    frame_d   = {frame_q[30:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(HDR_LEN - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StTa;
                    end
                end
            end
            StTa: begin
                mdio_oe = write_q;
                mdio_o  = frame_q[31];
                if (fall_en) begin
                    frame_d   = {frame_q[30:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                mdio_oe = write_q;
                mdio_o  = frame_q[31];
                // The PHY drives data while mdc is low; capture on the rising edge.
                if (rise_en && !write_q) begin
                    rd_sh_d = {rd_sh_q[14:0], mdio_i};
                end
                if (fall_en) begin
                    frame_d   = {frame_q[30:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(DATA_LEN - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StDone;
                        if (!write_q) begin
                            rdata_d = rd_sh_q;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            write_q   <= 1'b0;
            rd_sh_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            write_q   <= write_d;
            rd_sh_q   <= rd_sh_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_iob_eth_mdio_ctrl.sv
// Directed bench: write/read frames, back-to-back commands, mid-frame reset, MDC_DIV=5 read.
module tb_iob_eth_mdio_ctrl;

    localparam int D  = 2;
    localparam int D2 = 5;
`ifdef IOB_ETH_MDIO_PREAMBLE_EN
    localparam int NPRE = 32;
`else
    localparam int NPRE = 0;
`endif
    localparam int N = NPRE + 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_phyad, cmd_regad;
    logic [15:0] cmd_wdata, rsp_rdata;
    logic        rsp_valid, busy, mdc, mdio_o, mdio_oe, mdio_i;

    logic        c2_valid, c2_ready, c2_write;
    logic [4:0]  c2_phyad, c2_regad;
    logic [15:0] c2_wdata, c2_rdata;
    logic        c2_rsp_valid, c2_busy, c2_mdc, c2_mdio_o, c2_mdio_oe, c2_mdio_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_eth_mdio_ctrl #(.MDC_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phyad (cmd_phyad),
        .cmd_regad (cmd_regad),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    iob_eth_mdio_ctrl #(.MDC_DIV(D2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (c2_valid),
        .cmd_ready (c2_ready),
        .cmd_write (c2_write),
        .cmd_phyad (c2_phyad),
        .cmd_regad (c2_regad),
        .cmd_wdata (c2_wdata),
        .rsp_valid (c2_rsp_valid),
        .rsp_rdata (c2_rdata),
        .busy      (c2_busy),
        .mdc       (c2_mdc),
        .mdio_o    (c2_mdio_o),
        .mdio_oe   (c2_mdio_oe),
        .mdio_i    (c2_mdio_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] exp_rdata);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_mdc"},   {31'd0, mdc},       32'd0);
        chk({tag, "_mdo"},   {31'd0, mdio_o},    32'd1);
        chk({tag, "_oe"},    {31'd0, mdio_oe},   32'd0);
    endtask

    // One complete frame, checked cycle by cycle; abort_at > 0 resets in that cycle.
    task automatic run_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rad,
                             input logic [15:0] wd, input logic [15:0] phy_rd,
                             input logic keep, input int abort_at,
                             input logic [15:0] exp_rdata);
        logic [31:0] fr;
        bit          drive;
        int          cyc;
        fr = {2'b01, (wr ? 2'b01 : 2'b10), phy, rad, 2'b10, wd};
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_phyad = phy;
        cmd_regad = rad;
        cmd_wdata = wd;
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cyc = 1;
        if (!keep) cmd_valid = 1'b0;
        for (int b = 0; b < N; b++) begin
            for (int c = 0; c < 2 * D; c++) begin
                if (cyc == abort_at) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk_idle("abort", 16'h0000);
                    for (int k = 0; k < 4 * D; k++) begin
                        tick();
                        chk("abort_norsp", {31'd0, rsp_valid}, 32'd0);
                    end
                    return;
                end
                if (!wr && b >= NPRE + 16 && c == 0) mdio_i = phy_rd[15 - (b - NPRE - 16)];
                drive = wr || (b < NPRE + 14);
                chk("mdc",   {31'd0, mdc},       {31'd0, (c >= D)});
                chk("busy",  {31'd0, busy},      32'd1);
                chk("ready", {31'd0, cmd_ready}, 32'd0);
                chk("rspv",  {31'd0, rsp_valid}, 32'd0);
                chk("oe",    {31'd0, mdio_oe},   {31'd0, drive});
                if (drive) begin
                    chk("mdio_o", {31'd0, mdio_o},
                        {31'd0, (b < NPRE) ? 1'b1 : fr[31 - (b - NPRE)]});
                end
                tick();
                cyc++;
            end
        end
        chk("done_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("done_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        chk("done_mdc",   {31'd0, mdc},       32'd0);
        chk("done_oe",    {31'd0, mdio_oe},   32'd0);
        chk("done_busy",  {31'd0, busy},      32'd1);
        chk("done_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk_idle("post", exp_rdata);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_phyad = '0;
        cmd_regad = '0;
        cmd_wdata = '0;
        mdio_i    = 1'b1;
        c2_valid  = 1'b0;
        c2_write  = 1'b0;
        c2_phyad  = '0;
        c2_regad  = '0;
        c2_wdata  = '0;
        c2_mdio_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset", 16'h0000);
        tick();
        chk_idle("idle", 16'h0000);

        run_frame(1'b1, 5'h01, 5'h00, 16'h8000, 16'h0000, 1'b0, 0, 16'h0000);
        run_frame(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, 1'b0, 0, 16'h0141);
        run_frame(1'b1, 5'h1F, 5'h1A, 16'h5A3C, 16'h0000, 1'b0, 0, 16'h0141);

        // cmd_valid held through the first frame: the second starts right after DONE.
        run_frame(1'b0, 5'h07, 5'h11, 16'h0000, 16'hBEEF, 1'b1, 0, 16'hBEEF);
        run_frame(1'b1, 5'h07, 5'h11, 16'h1234, 16'h0000, 1'b0, 0, 16'hBEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b2b_idle", {31'd0, busy}, 32'd0);
        end

        run_frame(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, 1'b0, 100, 16'h0000);
        run_frame(1'b0, 5'h0A, 5'h15, 16'h0000, 16'hA5C3, 1'b0, 0, 16'hA5C3);

        c2_valid  = 1'b1;
        c2_phyad  = 5'h03;
        c2_regad  = 5'h02;
        c2_mdio_i = 1'b1;
        chk("d5_ready", {31'd0, c2_ready}, 32'd1);
        tick();
        c2_valid = 1'b0;
        for (int cyc = 1; cyc <= N * 2 * D2; cyc++) begin
            int b;
            int c;
            b = (cyc - 1) / (2 * D2);
            c = (cyc - 1) % (2 * D2);
            chk("d5_mdc", {31'd0, c2_mdc}, {31'd0, (c >= D2)});
            chk("d5_rspv", {31'd0, c2_rsp_valid}, 32'd0);
            if (b == NPRE && c == 0) chk("d5_st0", {31'd0, c2_mdio_o}, 32'd0);
            if (b == NPRE + 1 && c == 0) chk("d5_st1", {31'd0, c2_mdio_o}, 32'd1);
            tick();
        end
        chk("d5_done_rspv",  {31'd0, c2_rsp_valid}, 32'd1);
        chk("d5_done_rdata", {16'd0, c2_rdata},     32'h0000FFFF);
        tick();
        chk("d5_post_rspv", {31'd0, c2_rsp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iob_eth_mdio_ctrl.md
IOB_ETH_MDIO_CTRL -- requirements
Module: iob_eth_mdio_ctrl

Interface
REQ-001 SHALL have parameter MDC_DIV, default 20, meaning clk cycles per MDC half-period; legal range 2..255.
REQ-002 SHALL have these ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accept.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_phyad, in, 5: PHY address.
- cmd_regad, in, 5: register address.
- cmd_wdata, in, 16: write data.
- rsp_valid, out, 1: completion pulse.
- rsp_rdata, out, 16: last read data.
- busy, out, 1: frame in progress.
- mdc, out, 1: management clock.
- mdio_o, out, 1: MDIO drive value.
- mdio_oe, out, 1: MDIO output enable.
- mdio_i, in, 1: MDIO sampled value.

Function
REQ-003 SHALL accept a command on the clk edge where cmd_valid and cmd_ready are both high, and SHALL latch write, phyad, regad and wdata on that edge.
REQ-004 SHALL drive cmd_ready high only in IDLE; cmd_valid while busy SHALL be ignored with no queueing.
REQ-005 SHALL use FSM states IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE; PRE SHALL be skipped per REQ-017.
REQ-006 Frame content, MSB first:
- PRE: 32 ones.
- HDR: ST=01, OP (read=10, write=01), PHYAD[4:0], REGAD[4:0]; 14 bits.
- TA: write drives 10; read drives nothing.
- DATA: 16 bits.
REQ-007 Each bit SHALL last 2*MDC_DIV clk cycles: mdc low for MDC_DIV cycles, then high for MDC_DIV cycles.
REQ-008 The first bit SHALL start the cycle after acceptance with mdc=0; mdio_o SHALL change only at bit boundaries, i.e. on the mdc high-to-low transition.
REQ-009 Read: mdio_oe SHALL be 0 throughout TA and DATA; mdio_i SHALL be sampled on the clk edge where mdc goes 0->1 during each DATA bit and shifted in MSB first.
REQ-010 Write: mdio_oe SHALL be 1 from the first bit through the last DATA bit.
REQ-011 After the last bit's high phase, SHALL enter DONE: mdc=0, mdio_oe=0, rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-012 Acceptance-to-rsp_valid latency SHALL be exactly 1 + N*2*MDC_DIV cycles, with N = 64 (preamble on) or 32 (preamble off).
REQ-013 rsp_rdata SHALL update only when a read reaches DONE and SHALL hold its value across writes; rsp_valid SHALL pulse for writes too.
REQ-014 busy SHALL be high in every state except IDLE; a new command SHALL be acceptable in the cycle after DONE.
REQ-015 In IDLE: mdc=0, mdio_oe=0, mdio_o=1, divider counter held at 0.

Reset
REQ-016 rst SHALL take effect at the next clk edge, including mid-frame, and SHALL abort any frame with no rsp_valid. Reset values: state=IDLE, cmd_ready=1 (after the reset edge), rsp_valid=0, rsp_rdata=0, busy=0, mdc=0, mdio_o=1, mdio_oe=0; bit and divider counters cleared.

Configuration
REQ-017 Macro IOB_ETH_MDIO_PREAMBLE_EN:
- Defined: every frame SHALL begin with the 32-bit PRE.
- Undefined: PRE SHALL be omitted (preamble suppression) and frames SHALL start at ST, N=32.

Structure
REQ-018 Package iob_eth_mdio_pkg SHALL hold the FSM state typedef and constants PRE_LEN=32, HDR_LEN=14, DATA_LEN=16, ST=2'b01, OP_RD=2'b10, OP_WR=2'b01, TA_WR=2'b10.
REQ-019 Sub-module iob_eth_mdc_gen SHALL hold the divider and output mdc plus one-cycle rise_en and fall_en strobes; the FSM SHALL advance only on those strobes.

Verification (MDC_DIV=2 unless stated)
REQ-020 Write phyad=0x01, regad=0x00, wdata=0x8000, preamble on -> serial stream 32x'1', 01 01 00001 00000 10 1000000000000000; mdio_oe=1 for all 64 bits; rsp_valid at cycle 257.
REQ-021 Read phyad=0x03, regad=0x02, PHY model returns 0x0141 -> mdio_oe drops at TA; rsp_rdata=0x0141 with rsp_valid at cycle 257; a following write leaves rsp_rdata=0x0141.
REQ-022 cmd_valid held high through a whole frame -> exactly two transactions back-to-back; cmd_ready low from cycle 1 to the DONE cycle.
REQ-023 rst asserted at cycle 100 of a read -> next cycle all outputs at reset values, no rsp_valid; a new read then completes normally.
REQ-024 IOB_ETH_MDIO_PREAMBLE_EN undefined, read with MDC_DIV=5 -> first bits 0,1 (ST); rsp_valid at cycle 321; mdc period 10 cycles, 50% duty.
